// File: rtl/axis_frame_tagger.sv
// Frames an unframed AXI-Stream into DATA_CNT-beat frames tagged with tuser (first) and tlast (last).
// Optional build macro AXIS_FRAME_TAGGER_STATS_EN adds a 32-bit frame_cnt output of emitted frames.
module axis_frame_tagger #(
   parameter int DW       = 16,
   parameter int DATA_CNT = 1024
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          enable,
   input  logic [DW-1:0] tdata_s,
   input  logic          tvalid_s,
   output logic          tready_s,
   output logic [DW-1:0] tdata_m,
   output logic          tuser_m,
   output logic          tlast_m,
   output logic          tvalid_m,
   input  logic          tready_m,
`ifdef AXIS_FRAME_TAGGER_STATS_EN
   output logic [31:0]   frame_cnt,
`endif
   output logic          busy
);

   localparam int            IW      = (DATA_CNT > 2) ? $clog2(DATA_CNT) : 1;
   localparam logic [IW-1:0] IDX_TOP = IW'(DATA_CNT - 1);
   localparam logic [IW-1:0] IDX_ONE = IW'(1);
   localparam logic [IW-1:0] IDX_ZERO = IW'(0);
   localparam int            WW      = DW + 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t          state_r;
   state_t          state_nxt_s;
   logic [IW-1:0]   idx_r;
   logic [IW-1:0]   idx_nxt_s;
   logic [1:0]      cnt_r;
   logic [1:0]      cnt_nxt_s;
   logic [WW-1:0]   out_r;
   logic [WW-1:0]   out_nxt_s;
   logic [WW-1:0]   skid_r;
   logic [WW-1:0]   skid_nxt_s;
   logic [WW-1:0]   in_word_s;
   logic            valid_r;
   logic            valid_nxt_s;
   logic            ready_r;
   logic            ready_nxt_s;
   logic            busy_r;
   logic            busy_nxt_s;
   logic            push_s;
   logic            pop_s;
   logic            first_s;
   logic            last_s;

   // Handshake qualifiers and the tags that travel with each accepted sample
   always_comb begin
      push_s    = tvalid_s & ready_r;
      pop_s     = valid_r & tready_m;
      first_s   = (idx_r == IDX_TOP);
      last_s    = (idx_r == IDX_ZERO);
      in_word_s = {first_s, last_s, tdata_s};
   end

   // Next-state logic: leaving RUN mid-frame goes through DRAIN so frames always complete
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (enable) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (enable) begin
               state_nxt_s = RUN;
            end else if (push_s) begin
               state_nxt_s = last_s ? IDLE : DRAIN;
            end else if (first_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         DRAIN: begin
            if (push_s && last_s) begin
               state_nxt_s = enable ? RUN : IDLE;
            end else if (enable) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Frame position counter: counts down per accepted beat and wraps on the tlast beat
   always_comb begin
      idx_nxt_s = idx_r;
      if (push_s) begin
         if (last_s) begin
            idx_nxt_s = IDX_TOP;
         end else begin
            idx_nxt_s = idx_r - IDX_ONE;
         end
      end else begin
         idx_nxt_s = idx_r;
      end
   end

   // Two-entry skid buffer: out_r is the presented beat, skid_r catches one beat during a stall
   always_comb begin
      out_nxt_s  = out_r;
      skid_nxt_s = skid_r;
      cnt_nxt_s  = cnt_r;
      case (cnt_r)
         2'd0: begin
            if (push_s) begin
               out_nxt_s = in_word_s;
               cnt_nxt_s = 2'd1;
            end else begin
               cnt_nxt_s = 2'd0;
            end
         end
         2'd1: begin
            if (push_s && pop_s) begin
               out_nxt_s = in_word_s;
            end else if (push_s) begin
               skid_nxt_s = in_word_s;
               cnt_nxt_s  = 2'd2;
            end else if (pop_s) begin
               cnt_nxt_s = 2'd0;
            end else begin
               cnt_nxt_s = 2'd1;
            end
         end
         2'd2: begin
            if (pop_s) begin
               out_nxt_s = skid_r;
               cnt_nxt_s = 2'd1;
            end else begin
               cnt_nxt_s = 2'd2;
            end
         end
         default: begin
            cnt_nxt_s = 2'd0;
         end
      endcase
      // tready_s looks only at next occupancy and state, so a full buffer never sees a push
      valid_nxt_s = (cnt_nxt_s != 2'd0);
      ready_nxt_s = (state_nxt_s != IDLE) && (cnt_nxt_s != 2'd2);
      busy_nxt_s  = (state_nxt_s != IDLE);
   end

   // State and frame counter registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
         idx_r   <= IDX_TOP;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         idx_r   <= idx_nxt_s;
         busy_r  <= busy_nxt_s;
      end
   end

   // Buffer and handshake registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_r   <= {WW{1'b0}};
         skid_r  <= {WW{1'b0}};
         cnt_r   <= 2'd0;
         valid_r <= 1'b0;
         ready_r <= 1'b0;
      end else begin
         out_r   <= out_nxt_s;
         skid_r  <= skid_nxt_s;
         cnt_r   <= cnt_nxt_s;
         valid_r <= valid_nxt_s;
         ready_r <= ready_nxt_s;
      end
   end

`ifdef AXIS_FRAME_TAGGER_STATS_EN
   logic [31:0] frame_cnt_r;

   // Emitted-frame counter, wraps naturally at 2^32
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt_r <= 32'd0;
      end else if (pop_s && out_r[DW]) begin
         frame_cnt_r <= frame_cnt_r + 32'd1;
      end else begin
         frame_cnt_r <= frame_cnt_r;
      end
   end

   assign frame_cnt = frame_cnt_r;
`endif

   assign tdata_m  = out_r[DW-1:0];
   assign tlast_m  = out_r[DW];
   assign tuser_m  = out_r[DW+1];
   assign tvalid_m = valid_r;
   assign tready_s = ready_r;
   assign busy     = busy_r;

endmodule

// File: tb/tb_axis_frame_tagger.sv
// Scoreboard bench for axis_frame_tagger: lane 0 uses DATA_CNT=1024, lane 1 uses DATA_CNT=4.
// Expected tags come from the count of accepted beats since reset, modulo the frame length.
`timescale 1ns/1ps
module tb_axis_frame_tagger;
   localparam int DW = 16;
   localparam int NL = 2;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   always #5 clk = ~clk;

   logic          enable   [NL];
   logic [DW-1:0] tdata_s  [NL];
   logic          tvalid_s [NL];
   logic          tready_s [NL];
   logic [DW-1:0] tdata_m  [NL];
   logic          tuser_m  [NL];
   logic          tlast_m  [NL];
   logic          tvalid_m [NL];
   logic          tready_m [NL];
   logic          busy     [NL];
`ifdef AXIS_FRAME_TAGGER_STATS_EN
   logic [31:0]   frame_cnt [NL];
`endif

   for (genvar g = 0; g < NL; g++) begin : g_lane
      axis_frame_tagger #(.DW(DW), .DATA_CNT(g == 0 ? 1024 : 4)) u_dut (
         .clk      (clk),
         .reset_n  (reset_n),
         .enable   (enable[g]),
         .tdata_s  (tdata_s[g]),
         .tvalid_s (tvalid_s[g]),
         .tready_s (tready_s[g]),
         .tdata_m  (tdata_m[g]),
         .tuser_m  (tuser_m[g]),
         .tlast_m  (tlast_m[g]),
         .tvalid_m (tvalid_m[g]),
         .tready_m (tready_m[g]),
`ifdef AXIS_FRAME_TAGGER_STATS_EN
         .frame_cnt(frame_cnt[g]),
`endif
         .busy     (busy[g])
      );
   end

   int total = 0;
   int bad = 0;
   int ph = 0;
   int done_ph = 0;
   int timeouts = 0;
   int c_drop = 0;
   int tp_cyc = 0;
   int tp_hs = 0;
   int vmode [NL];
   int rmode [NL];

   logic [DW+1:0] expq [NL][$];
   int            acc_n  [NL];
   int            occ    [NL];
   int            frames [NL];
   bit            stall  [NL];
   bit            took   [NL];
   logic [DW+1:0] held   [NL];

   function automatic int nfr(input int l);
      return (l == 0) ? 1024 : 4;
   endfunction

   task automatic chk(input int l, input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s lane=%0d actual=%0h required=%0h t=%0t", name, l, act, exp, $time);
      end
   endtask

   // Monitor: model occupancy, compare presented beats to the scoreboard, run phase checks
   always @(negedge clk) begin
      for (int l = 0; l < NL; l++) begin
         logic [DW+1:0] word;
         logic [DW+1:0] e;
         bit popv;
         bit pushv;
         int n;
         n = nfr(l);
         word = {tuser_m[l], tlast_m[l], tdata_m[l]};
         if (!reset_n) begin
            chk(l, "rst_tvalid_m", tvalid_m[l], 0);
            chk(l, "rst_tready_s", tready_s[l], 0);
            chk(l, "rst_busy", busy[l], 0);
            chk(l, "rst_out_word", word, 0);
`ifdef AXIS_FRAME_TAGGER_STATS_EN
            chk(l, "rst_frame_cnt", frame_cnt[l], 0);
`endif
            expq[l].delete();
            acc_n[l] = 0;
            occ[l] = 0;
            frames[l] = 0;
            stall[l] = 1'b0;
            took[l] = 1'b0;
         end else begin
            popv = tvalid_m[l] && tready_m[l];
            pushv = tvalid_s[l] && tready_s[l];
            chk(l, "valid_vs_occupancy", tvalid_m[l], occ[l] != 0);
            if (occ[l] == 2) chk(l, "full_blocks_input", tready_s[l], 0);
            if (stall[l]) begin
               chk(l, "stall_valid_held", tvalid_m[l], 1);
               chk(l, "stall_word_held", word, held[l]);
            end
`ifdef AXIS_FRAME_TAGGER_STATS_EN
            chk(l, "frame_cnt", frame_cnt[l], frames[l]);
`endif
            if (popv) begin
               if (expq[l].size() == 0) begin
                  chk(l, "spurious_beat_valid", tvalid_m[l], 0);
               end else begin
                  e = expq[l].pop_front();
                  chk(l, "beat_user_last_data", word, e);
                  if (e[DW]) frames[l]++;
               end
            end
            stall[l] = tvalid_m[l] && !tready_m[l];
            held[l] = word;
            if (pushv) begin
               expq[l].push_back({(acc_n[l] % n) == 0, (acc_n[l] % n) == (n - 1), tdata_s[l]});
               acc_n[l]++;
            end
            occ[l] = occ[l] + int'(pushv) - int'(popv);
            took[l] = pushv;
         end
      end
      if (ph == 1) begin
         tp_cyc++;
         if (tvalid_m[0] && tready_m[0]) tp_hs++;
      end
      if (ph == 2 && done_ph != 2) begin
         chk(0, "throughput_beats", tp_hs, tp_cyc);
         done_ph = 2;
      end
      if (ph == 3 && done_ph != 3) begin
         chk(0, "drain_tready_s", tready_s[0], 0);
         chk(0, "drain_busy", busy[0], 0);
         chk(0, "drain_accepted", acc_n[0], c_drop + 524);
         chk(0, "drain_queue_empty", expq[0].size(), 0);
         done_ph = 3;
      end
      if (ph == 4 && done_ph != 4) begin
         for (int l = 0; l < NL; l++) chk(l, "end_queue_empty", expq[l].size(), 0);
         chk(0, "wait_timeouts", timeouts, 0);
         done_ph = 4;
      end
   end

   // One cycle of stimulus: advance ramp on acceptance, hold tvalid until handshake
   task automatic step();
      @(posedge clk);
      #1;
      for (int l = 0; l < NL; l++) begin
         if (took[l]) tdata_s[l] = tdata_s[l] + 1'b1;
         if (vmode[l] == 0) tvalid_s[l] = 1'b0;
         else if (!tvalid_s[l] || took[l])
            tvalid_s[l] = (vmode[l] == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
         tready_m[l] = (rmode[l] == 1) ? 1'b1 : (rmode[l] == 2) ? ($urandom_range(0, 1) == 1) : 1'b0;
      end
   endtask

   task automatic run_to_beat(input int beat);
      int guard;
      guard = 0;
      while ((acc_n[0] % 1024) != beat && guard < 5000) begin
         step();
         guard++;
      end
      if (guard >= 5000) timeouts++;
   endtask

   initial begin
      for (int l = 0; l < NL; l++) begin
         enable[l] = 1'b0;
         tdata_s[l] = '0;
         tvalid_s[l] = 1'b0;
         tready_m[l] = 1'b0;
         vmode[l] = 0;
         rmode[l] = 0;
      end
      #1 reset_n = 1'b0;
      repeat (3) step();
      reset_n = 1'b1;
      step();
      // Full-rate ramp on lane 0, gapped input on the 4-beat lane
      enable[0] = 1'b1; vmode[0] = 1; rmode[0] = 1;
      enable[1] = 1'b1; vmode[1] = 2; rmode[1] = 1;
      repeat (20) step();
      ph = 1;
      repeat (2000) step();
      ph = 2;
      // Random backpressure, random input gaps and short enable drops
      vmode[0] = 2; rmode[0] = 2; rmode[1] = 2;
      for (int i = 0; i < 3000; i++) begin
         step();
         enable[0] = ($urandom_range(0, 19) != 0);
         enable[1] = ($urandom_range(0, 19) != 0);
      end
      enable[0] = 1'b1; enable[1] = 1'b1;
      vmode[0] = 1; rmode[0] = 1;
      // Drop enable at beat 500 of a frame and let the frame drain
      run_to_beat(500);
      c_drop = acc_n[0];
      enable[0] = 1'b0;
      repeat (700) step();
      ph = 3;
      repeat (2) step();
      // Reset in the middle of a frame, then run two fresh frames
      enable[0] = 1'b1;
      run_to_beat(300);
      reset_n = 1'b0;
      repeat (3) step();
      reset_n = 1'b1;
      repeat (2200) step();
      for (int l = 0; l < NL; l++) begin
         vmode[l] = 0;
         rmode[l] = 1;
      end
      repeat (20) step();
      ph = 4;
      repeat (3) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
